// File: rtl/decoder_pkg.sv
// Shared types and constants for the 4-to-16 decoder address sequencer.
package decoder_pkg;
  localparam int ADDR_W  = 4;
  localparam int NUM_OUT = 16;
  localparam int DWELL_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Modulo-16 step; wrap in either direction is intentional.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input logic d);
    return (d == DIR_DOWN) ? a - ADDR_W'(1) : a + ADDR_W'(1);
  endfunction
endpackage

// File: rtl/decoder_scan_if.sv
// Control/select bundle between a scan requester and decoder_scan_ctrl.
interface decoder_scan_if;
  import decoder_pkg::*;

  // start is a request level sampled only while idle; busy going high on the
  // following edge is the acceptance. stop aborts; done is a one-cycle pulse.
  logic               start;
  logic               stop;
  logic               dir;
  logic [ADDR_W-1:0]  first;
  logic [ADDR_W-1:0]  last;
  logic [DWELL_W-1:0] dwell;
  logic [ADDR_W-1:0]  w;
  logic               en;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, dir, first, last, dwell,
    input  w, en, busy, done
  );

  modport slave (
    input  start, stop, dir, first, last, dwell,
    output w, en, busy, done
  );
endinterface

// File: rtl/dwell_counter.sv
// Loadable down-counter timing how long each address is held; saturates at 0.
module dwell_counter
  import decoder_pkg::*;
#(
  parameter int W = DWELL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = value;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/decoder_scan_ctrl.sv
// Address sequencer driving the 4-to-16 decoder select word and enable.
// Optional SCAN_LOOP_EN: restart from first after each pass until stop.
module decoder_scan_ctrl
  import decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  decoder_scan_if.slave        bus,
  output scan_state_t          state_dbg
);
  scan_state_t        state_q, state_d;
  logic [ADDR_W-1:0]  w_q, w_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dir_q, dir_d;
  logic [ADDR_W-1:0]  first_q, first_d;
  logic [ADDR_W-1:0]  last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               cnt_load, cnt_dec, cnt_zero;
  logic [DWELL_W-1:0] cnt_value;

  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    en_d      = en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dir_d     = dir_q;
    first_d   = first_q;
    last_d    = last_q;
    dwell_d   = dwell_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_value = dwell_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          dir_d     = bus.dir;
          first_d   = bus.first;
          last_d    = bus.last;
          dwell_d   = bus.dwell;
          w_d       = bus.first;
          en_d      = 1'b1;
          busy_d    = 1'b1;
          cnt_load  = 1'b1;
          cnt_value = bus.dwell;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        // stop outranks completion, so an abort never produces done
        if (bus.stop) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (w_q != last_q) begin
          w_d      = step_addr(w_q, dir_q);
          cnt_load = 1'b1;
        end else begin
          done_d = 1'b1;
`ifdef SCAN_LOOP_EN
          w_d      = first_q;
          cnt_load = 1'b1;
`else
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= DIR_UP;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      first_q <= first_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
    end
  end

  assign bus.w     = w_q;
  assign bus.en    = en_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign state_dbg = state_q;
endmodule
